// File: rtl/tetris_game_seq.sv
// rtl/tetris_game_seq.sv - game-phase sequencer driving the 8x4 Tetris board datapath
// TETRIS_SEQ_FIXED_PIECE_EN: pieces cycle 0..3 per spawn instead of coming from the LFSR.
module tetris_game_seq #(
  parameter int TICK_DIV    = 1000,
  parameter int ACK_TIMEOUT = 255,
  parameter int SCORE_W     = 8
) (
  input  logic               clka,
  input  logic               restart_n,
  input  logic               start,
  input  logic [31:0]        board,
  input  logic               dp_ack,
  input  logic               dp_error,
  input  logic               landed,
  output logic [2:0]         state,
  output logic [1:0]         curr_piece,
  output logic               cmd_valid,
  output logic [SCORE_W-1:0] lines,
  output logic               game_over,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_GEN_W, S_FALL, S_FALL_W, S_CLEAR, S_CLEAR_W, S_OVER
  } fsm_e;

  localparam logic [2:0] PH_GEN   = 3'd0;
  localparam logic [2:0] PH_FALL  = 3'd1;
  localparam logic [2:0] PH_CLEAR = 3'd2;
  localparam logic [2:0] PH_IDLE  = 3'd3;
  localparam logic [2:0] PH_OVER  = 3'd4;

  localparam int TW = $clog2(TICK_DIV);
  localparam int WW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(ACK_TIMEOUT - 1);

  fsm_e               fsm_q, fsm_d;
  logic [2:0]         state_q, state_d;
  logic [1:0]         piece_q, piece_d, piece_src;
  logic               cmd_q, cmd_d;
  logic               over_q, over_d;
  logic [SCORE_W-1:0] lines_q, lines_d, lines_sat;
  logic [TW-1:0]      tick_q, tick_d;
  logic [WW-1:0]      wd_q, wd_d;
  logic [3:0]         fullb_q, fullb_d, full_now, delta;
  logic [SCORE_W+3:0] lines_sum;
  logic               ack_ok;

  function automatic logic [3:0] count_full(input logic [31:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int r = 0; r < 8; r++) begin
      if (b[4*r +: 4] == 4'hF) n = n + 4'd1;
    end
    return n;
  endfunction

  // An ack coincident with the command strobe belongs to no command yet.
  assign ack_ok    = dp_ack & ~cmd_q;
  assign full_now  = count_full(board);
  assign delta     = (fullb_q > full_now) ? (fullb_q - full_now) : 4'd0;
  assign lines_sum = {4'b0000, lines_q} + {{SCORE_W{1'b0}}, delta};
  assign lines_sat = (lines_sum[SCORE_W+3:SCORE_W] != 4'd0) ? {SCORE_W{1'b1}}
                                                             : lines_sum[SCORE_W-1:0];

`ifdef TETRIS_SEQ_FIXED_PIECE_EN
  logic [1:0] seq_q, seq_d;

  always_comb begin
    seq_d = seq_q;
    if (fsm_q == S_GEN) seq_d = seq_q + 2'd1;
    else if (fsm_q == S_OVER && start) seq_d = 2'd0;
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) seq_q <= 2'd0;
    else            seq_q <= seq_d;
  end

  assign piece_src = seq_q;
`else
  logic [7:0] lfsr_q;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) lfsr_q <= 8'hA5;
    else            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign piece_src = lfsr_q[1:0];
`endif

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    piece_d = piece_q;
    cmd_d   = 1'b0;
    lines_d = lines_q;
    over_d  = over_q;
    tick_d  = tick_q;
    wd_d    = wd_q;
    fullb_d = fullb_q;
    case (fsm_q)
      S_IDLE: if (start) fsm_d = S_GEN;
      S_GEN: begin
        piece_d = piece_src;
        cmd_d   = 1'b1;
        state_d = PH_GEN;
        wd_d    = '0;
        fsm_d   = S_GEN_W;
      end
      S_FALL: begin
        if (tick_q == TICK_LAST) begin
          cmd_d   = 1'b1;
          state_d = PH_FALL;
          wd_d    = '0;
          fsm_d   = S_FALL_W;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      S_CLEAR: begin
        if (full_now == 4'd0) begin
          fsm_d = S_GEN;
        end else begin
          fullb_d = full_now;
          cmd_d   = 1'b1;
          state_d = PH_CLEAR;
          wd_d    = '0;
          fsm_d   = S_CLEAR_W;
        end
      end
      S_GEN_W, S_FALL_W, S_CLEAR_W: begin
        // A valid ack takes priority over watchdog expiry in the same cycle.
        if (ack_ok) begin
          if (fsm_q == S_GEN_W) begin
            if (dp_error) begin
              fsm_d   = S_OVER;
              state_d = PH_OVER;
              over_d  = 1'b1;
            end else begin
              fsm_d  = S_FALL;
              tick_d = '0;
            end
          end else if (fsm_q == S_FALL_W) begin
            if (landed) begin
              fsm_d = S_CLEAR;
            end else begin
              fsm_d  = S_FALL;
              tick_d = '0;
            end
          end else begin
            lines_d = lines_sat;
            fsm_d   = S_CLEAR;
          end
        end else if (wd_q == WD_LAST) begin
          fsm_d   = S_OVER;
          state_d = PH_OVER;
          over_d  = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_OVER: begin
        if (start) begin
          lines_d = '0;
          over_d  = 1'b0;
          fsm_d   = S_GEN;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      fsm_q   <= S_IDLE;
      state_q <= PH_IDLE;
      piece_q <= 2'd0;
      cmd_q   <= 1'b0;
      lines_q <= '0;
      over_q  <= 1'b0;
      tick_q  <= '0;
      wd_q    <= '0;
      fullb_q <= 4'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      piece_q <= piece_d;
      cmd_q   <= cmd_d;
      lines_q <= lines_d;
      over_q  <= over_d;
      tick_q  <= tick_d;
      wd_q    <= wd_d;
      fullb_q <= fullb_d;
    end
  end

  assign state      = state_q;
  assign curr_piece = piece_q;
  assign cmd_valid  = cmd_q;
  assign lines      = lines_q;
  assign game_over  = over_q;
  assign busy       = (fsm_q != S_IDLE) && (fsm_q != S_OVER);

endmodule

// File: tb/tb_tetris_game_seq.sv
// tb/tb_tetris_game_seq.sv - randomized self-checking bench for tetris_game_seq
module tb_tetris_game_seq;
  localparam int TICK_DIV    = 4;
  localparam int ACK_TIMEOUT = 12;
  localparam int SCORE_W     = 4;
  localparam int LINES_MAX   = (1 << SCORE_W) - 1;

  logic               clka = 1'b0;
  logic               restart_n = 1'b0;
  logic               start = 1'b0;
  logic [31:0]        board = 32'h0;
  logic               dp_ack = 1'b0;
  logic               dp_error = 1'b0;
  logic               landed = 1'b0;
  logic [2:0]         state;
  logic [1:0]         curr_piece;
  logic               cmd_valid;
  logic [SCORE_W-1:0] lines;
  logic               game_over;
  logic               busy;

  int vectors = 0;
  int miscompares = 0;
  int m_lines = 0;
  int m_spawn = 0;
  logic [7:0] m_lfsr, m_lfsr_prev;

  always #5 clka = ~clka;

  tetris_game_seq #(.TICK_DIV(TICK_DIV), .ACK_TIMEOUT(ACK_TIMEOUT), .SCORE_W(SCORE_W)) dut (
    .clka(clka), .restart_n(restart_n), .start(start), .board(board),
    .dp_ack(dp_ack), .dp_error(dp_error), .landed(landed), .state(state),
    .curr_piece(curr_piece), .cmd_valid(cmd_valid), .lines(lines),
    .game_over(game_over), .busy(busy)
  );

  // Piece-source reference: 8-bit Fibonacci LFSR, taps 8,6,5,4, stepping every cycle.
  always @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      m_lfsr      <= 8'hA5;
      m_lfsr_prev <= 8'hA5;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
  end

  function automatic logic [1:0] exp_piece();
`ifdef TETRIS_SEQ_FIXED_PIECE_EN
    return m_spawn[1:0];
`else
    return m_lfsr_prev[1:0];
`endif
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > LINES_MAX) ? LINES_MAX : a + b;
  endfunction

  function automatic logic [31:0] make_board(input int nfull);
    logic [31:0] b;
    for (int r = 0; r < 8; r++)
      b[4*r +: 4] = (r >= 8 - nfull) ? 4'hF : 4'($urandom_range(0, 14));
    return b;
  endfunction

  task automatic wait_cmd(output int cyc);
    int i;
    i = 0;
    cyc = -1;
    while (cyc < 0 && i < 64) begin
      @(negedge clka);
      i++;
      if (cmd_valid === 1'b1) cyc = i;
    end
  endtask

  task automatic drive_ack(input int dly, input logic err, input logic lnd, input logic [31:0] brd);
    repeat (dly) @(negedge clka);
    dp_ack = 1'b1; dp_error = err; landed = lnd; board = brd;
    @(negedge clka);
    dp_ack = 1'b0; dp_error = 1'b0; landed = 1'b0;
  endtask

  task automatic test_reset;
    restart_n = 1'b0;
    repeat (3) @(negedge clka);
    vectors++; if (state !== 3'd3) begin miscompares++; $display("FAIL reset_state: got %0d want 3", state); end
    vectors++; if (curr_piece !== 2'd0) begin miscompares++; $display("FAIL reset_piece: got %0d want 0", curr_piece); end
    vectors++; if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_cmd: got %b want 0", cmd_valid); end
    vectors++; if (lines !== '0) begin miscompares++; $display("FAIL reset_lines: got %0d want 0", lines); end
    vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL reset_over: got %b want 0", game_over); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    restart_n = 1'b1;
    m_lines = 0; m_spawn = 0;
    repeat (2) @(negedge clka);
    vectors++; if (busy !== 1'b0 || state !== 3'd3) begin miscompares++; $display("FAIL idle_hold: got busy=%b state=%0d want 0/3", busy, state); end
  endtask

  task automatic test_start;
    int c;
    start = 1'b1; @(negedge clka); start = 1'b0;
    wait_cmd(c);
    vectors++; if (c + 1 !== 2) begin miscompares++; $display("FAIL start_lat: got %0d want 2", c + 1); end
    vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL gen_state: got %0d want 0", state); end
    vectors++; if (curr_piece !== exp_piece()) begin miscompares++; $display("FAIL gen_piece: got %0d want %0d", curr_piece, exp_piece()); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL gen_busy: got %b want 1", busy); end
    m_spawn++;
    drive_ack($urandom_range(1, 3), 1'b0, 1'b0, make_board(0));
    wait_cmd(c);
    vectors++; if (c + 1 !== TICK_DIV + 1) begin miscompares++; $display("FAIL fall_lat: got %0d want %0d", c + 1, TICK_DIV + 1); end
    vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL fall_state: got %0d want 1", state); end
  endtask

  task automatic test_clear_two;
    int c;
    drive_ack($urandom_range(1, 3), 1'b0, 1'b1, 32'hFF00_0000);
    wait_cmd(c);
    vectors++; if (c + 1 !== 2 || state !== 3'd2) begin miscompares++; $display("FAIL clear2_cmd: got lat=%0d state=%0d want 2/2", c + 1, state); end
    drive_ack($urandom_range(1, 3), 1'b0, 1'b0, 32'h0);
    m_lines = sat_add(m_lines, 2);
    vectors++; if (lines !== SCORE_W'(m_lines)) begin miscompares++; $display("FAIL clear2_lines: got %0d want %0d", lines, m_lines); end
    wait_cmd(c);
    vectors++; if (c + 1 !== 3 || state !== 3'd0) begin miscompares++; $display("FAIL clear2_gen: got lat=%0d state=%0d want 3/0", c + 1, state); end
    vectors++; if (curr_piece !== exp_piece()) begin miscompares++; $display("FAIL clear2_piece: got %0d want %0d", curr_piece, exp_piece()); end
    m_spawn++;
  endtask

  task automatic test_clear_three;
    int c;
    drive_ack($urandom_range(1, 3), 1'b0, 1'b0, make_board(0));
    wait_cmd(c);
    drive_ack($urandom_range(1, 3), 1'b0, 1'b1, 32'hFFF0_0000);
    wait_cmd(c);
    vectors++; if (c + 1 !== 2 || state !== 3'd2) begin miscompares++; $display("FAIL clear3_cmd1: got lat=%0d state=%0d want 2/2", c + 1, state); end
    drive_ack($urandom_range(1, 3), 1'b0, 1'b0, 32'hF000_0000);
    m_lines = sat_add(m_lines, 2);
    vectors++; if (lines !== SCORE_W'(m_lines)) begin miscompares++; $display("FAIL clear3_lines1: got %0d want %0d", lines, m_lines); end
    wait_cmd(c);
    vectors++; if (c + 1 !== 2 || state !== 3'd2) begin miscompares++; $display("FAIL clear3_cmd2: got lat=%0d state=%0d want 2/2", c + 1, state); end
    drive_ack($urandom_range(1, 3), 1'b0, 1'b0, 32'h0);
    m_lines = sat_add(m_lines, 1);
    vectors++; if (lines !== SCORE_W'(m_lines)) begin miscompares++; $display("FAIL clear3_lines2: got %0d want %0d", lines, m_lines); end
    wait_cmd(c);
    vectors++; if (c + 1 !== 3 || curr_piece !== exp_piece()) begin miscompares++; $display("FAIL clear3_gen: got lat=%0d piece=%0d want 3/%0d", c + 1, curr_piece, exp_piece()); end
    m_spawn++;
  endtask

  task automatic test_ack_same_cycle;
    int c;
    drive_ack(0, 1'b1, 1'b0, make_board(0));
    vectors++; if (game_over !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL early_ack: got over=%b busy=%b want 0/1", game_over, busy); end
    drive_ack($urandom_range(0, 2), 1'b0, 1'b0, make_board(0));
    wait_cmd(c);
    vectors++; if (c + 1 !== TICK_DIV + 1 || state !== 3'd1) begin miscompares++; $display("FAIL early_ack_fall: got lat=%0d state=%0d want %0d/1", c + 1, state, TICK_DIV + 1); end
  endtask

  task automatic test_ack_boundary;
    int c;
    drive_ack(ACK_TIMEOUT - 1, 1'b0, 1'b0, make_board(0));
    vectors++; if (game_over !== 1'b0) begin miscompares++; $display("FAIL late_ack_over: got %b want 0", game_over); end
    wait_cmd(c);
    vectors++; if (c + 1 !== TICK_DIV + 1 || state !== 3'd1) begin miscompares++; $display("FAIL late_ack_fall: got lat=%0d state=%0d want %0d/1", c + 1, state, TICK_DIV + 1); end
  endtask

  task automatic test_watchdog;
    int n;
    n = 0;
    while (game_over !== 1'b1 && n < 4 * ACK_TIMEOUT) begin
      @(negedge clka);
      n++;
    end
    vectors++; if (n !== ACK_TIMEOUT) begin miscompares++; $display("FAIL wd_cycles: got %0d want %0d", n, ACK_TIMEOUT); end
    vectors++; if (state !== 3'd4 || busy !== 1'b0) begin miscompares++; $display("FAIL wd_over: got state=%0d busy=%b want 4/0", state, busy); end
  endtask

  task automatic test_over_restart;
    int c;
    vectors++; if (lines !== SCORE_W'(m_lines)) begin miscompares++; $display("FAIL over_lines_hold: got %0d want %0d", lines, m_lines); end
    start = 1'b1; @(negedge clka); start = 1'b0;
    m_lines = 0; m_spawn = 0;
    vectors++; if (lines !== '0 || game_over !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL restart: got lines=%0d over=%b busy=%b want 0/0/1", lines, game_over, busy); end
    wait_cmd(c);
    vectors++; if (c !== 1 || state !== 3'd0 || curr_piece !== exp_piece()) begin miscompares++; $display("FAIL restart_gen: got lat=%0d state=%0d piece=%0d want 2/0/%0d", c + 1, state, curr_piece, exp_piece()); end
    m_spawn++;
    drive_ack($urandom_range(1, 3), 1'b1, 1'b0, make_board(0));
    vectors++; if (game_over !== 1'b1 || busy !== 1'b0 || state !== 3'd4) begin miscompares++; $display("FAIL gen_error: got over=%b busy=%b state=%0d want 1/0/4", game_over, busy, state); end
    start = 1'b1; @(negedge clka); start = 1'b0;
    m_lines = 0; m_spawn = 0;
    wait_cmd(c);
    vectors++; if (c !== 1 || state !== 3'd0 || curr_piece !== exp_piece() || lines !== '0) begin miscompares++; $display("FAIL error_restart: got lat=%0d state=%0d piece=%0d lines=%0d", c + 1, state, curr_piece, lines); end
    m_spawn++;
  endtask

  task automatic play_pieces(input int n, input bit force4);
    int c, nf, cur, nxt, iter;
    for (int p = 0; p < n; p++) begin
      drive_ack($urandom_range(1, 3), 1'b0, 1'b0, make_board(0));
      wait_cmd(c);
      vectors++; if (c + 1 !== TICK_DIV + 1 || state !== 3'd1) begin miscompares++; $display("FAIL play_fall: got lat=%0d state=%0d want %0d/1", c + 1, state, TICK_DIV + 1); end
      nf = $urandom_range(0, 2);
      for (int f = 0; f < nf; f++) begin
        drive_ack($urandom_range(1, 3), 1'b0, 1'b0, make_board(0));
        wait_cmd(c);
        vectors++; if (c + 1 !== TICK_DIV + 1) begin miscompares++; $display("FAIL play_refall: got %0d want %0d", c + 1, TICK_DIV + 1); end
      end
      cur = force4 ? 4 : $urandom_range(0, 4);
      drive_ack($urandom_range(1, 3), 1'b0, 1'b1, make_board(cur));
      iter = 0;
      while (cur > 0) begin
        wait_cmd(c);
        vectors++; if (c + 1 !== 2 || state !== 3'd2) begin miscompares++; $display("FAIL play_clear: got lat=%0d state=%0d want 2/2", c + 1, state); end
        iter++;
        nxt = (iter > 4) ? 0 : (($urandom_range(0, 5) == 0) ? cur : $urandom_range(0, cur - 1));
        drive_ack($urandom_range(1, 3), 1'b0, 1'b0, make_board(nxt));
        m_lines = sat_add(m_lines, cur - nxt);
        vectors++; if (lines !== SCORE_W'(m_lines)) begin miscompares++; $display("FAIL play_lines: got %0d want %0d", lines, m_lines); end
        cur = nxt;
      end
      wait_cmd(c);
      vectors++; if (c + 1 !== 3 || state !== 3'd0) begin miscompares++; $display("FAIL play_gen: got lat=%0d state=%0d want 3/0", c + 1, state); end
      vectors++; if (curr_piece !== exp_piece()) begin miscompares++; $display("FAIL play_piece: got %0d want %0d", curr_piece, exp_piece()); end
      m_spawn++;
    end
  endtask

  task automatic test_saturate;
    int c;
    drive_ack($urandom_range(1, 3), 1'b1, 1'b0, make_board(0));
    start = 1'b1; @(negedge clka); start = 1'b0;
    m_lines = 0; m_spawn = 0;
    wait_cmd(c);
    vectors++; if (c !== 1 || curr_piece !== exp_piece()) begin miscompares++; $display("FAIL sat_start: got lat=%0d piece=%0d want 2/%0d", c + 1, curr_piece, exp_piece()); end
    m_spawn++;
    play_pieces(5, 1'b1);
    vectors++; if (lines !== SCORE_W'(LINES_MAX)) begin miscompares++; $display("FAIL sat_final: got %0d want %0d", lines, LINES_MAX); end
  endtask

  task automatic test_reset_mid;
    int c, seen;
    drive_ack($urandom_range(1, 3), 1'b0, 1'b0, make_board(0));
    wait_cmd(c);
    drive_ack($urandom_range(1, 3), 1'b0, 1'b1, make_board(4));
    wait_cmd(c);
    #2 restart_n = 1'b0;
    #1;
    vectors++; if (state !== 3'd3 || cmd_valid !== 1'b0 || curr_piece !== 2'd0) begin miscompares++; $display("FAIL mid_reset_out: got state=%0d cmd=%b piece=%0d want 3/0/0", state, cmd_valid, curr_piece); end
    vectors++; if (lines !== '0 || game_over !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_cnt: got lines=%0d over=%b busy=%b want 0/0/0", lines, game_over, busy); end
    dp_ack = 1'b1;
    repeat (2) @(negedge clka);
    restart_n = 1'b1;
    m_lines = 0; m_spawn = 0;
    @(negedge clka);
    dp_ack = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clka);
      if (cmd_valid === 1'b1 || busy !== 1'b0) seen++;
    end
    vectors++; if (seen !== 0 || state !== 3'd3) begin miscompares++; $display("FAIL post_reset_idle: got activity=%0d state=%0d want 0/3", seen, state); end
    start = 1'b1; @(negedge clka); start = 1'b0;
    wait_cmd(c);
    vectors++; if (c !== 1 || curr_piece !== exp_piece()) begin miscompares++; $display("FAIL post_reset_gen: got lat=%0d piece=%0d want 2/%0d", c + 1, curr_piece, exp_piece()); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_start;
    test_clear_two;
    test_clear_three;
    test_ack_same_cycle;
    test_ack_boundary;
    test_watchdog;
    test_over_restart;
    play_pieces(12, 1'b0);
    test_saturate;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
